// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN calculator operand-stack read path.
//   - DEF_DATA_W / DEF_ADDR_W : default stack entry and address widths
//   - state_e                 : pop/peek engine FSM encoding (2-bit)
//   - op_e                    : latched operation type (peek or pop)
package rpn_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    typedef enum logic {
        OP_PEEK = 1'b0,
        OP_POP  = 1'b1
    } op_e;

endpackage

// File: rtl/rpn_stack_reader_if.sv
// Read port of the synchronous operand-stack RAM.
//   ram_addr : read address            (reader -> RAM)
//   ram_rden : read enable, one cycle   (reader -> RAM)
//   ram_q    : read data, valid RAM_LAT cycles after the ram_rden cycle (RAM -> reader)
// master = stack reader, slave = RAM.
interface rpn_stack_reader_if
    import rpn_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rden;
    logic [DATA_W-1:0] ram_q;

    modport master (
        output ram_addr,
        output ram_rden,
        input  ram_q
    );

    modport slave (
        input  ram_addr,
        input  ram_rden,
        output ram_q
    );

endinterface

// File: rtl/rise_detect.sv
// Rising-edge detector for a synchronised level request.
//   clk     : clock
//   rst     : asynchronous active-high reset (clears history)
//   level_i : synchronised level input
//   pulse_o : high for the one cycle in which level_i is high and was low
//             on the previous sampled edge
// History resets to 0, so a level held high through reset release is seen
// as a rising edge on the first sampled cycle.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic pulse_o
);

    logic hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= level_i;
        end
    end

    assign pulse_o = level_i & ~hist_q;

endmodule

// File: rtl/rpn_stack_reader.sv
// Pop/peek engine for the RPN calculator's RAM operand stack.
// A pop or peek request reads the top-of-stack entry (sp-1) from the
// synchronous RAM, presents it on pop_data with a one-cycle pop_valid
// strobe, and for a pop also pulses sp_dec to the stack pointer owner.
// Requests against an empty stack (sp==0) set a sticky underflow flag.
//
// Ports:
//   CLOCK_50    : clock, rising edge
//   reset       : asynchronous active-high reset
//   pop_req     : level request, rising edge starts a pop
//   peek_req    : level request, rising edge starts a peek
//   clr_err     : synchronous clear of underflow
//   sp          : stack pointer (next free slot), sampled at acceptance only
//   ram         : RAM read port (master side)
//   pop_data    : last value read, holds until the next read completes
//   pop_valid   : one-cycle strobe in the completion cycle
//   sp_dec      : one-cycle strobe alongside pop_valid, pops only
//   busy        : operation in progress; new request edges are dropped
//   underflow   : sticky empty-stack request flag
//   dbg_state_o : current FSM state
//
// Handshake: there is no backpressure. A request edge is accepted only in
// S_IDLE; edges seen while busy are consumed and lost. pop_valid/sp_dec are
// single-cycle strobes that the consumer must take in that cycle; pop_data
// is registered at the end of the pop_valid cycle, so consumers sample it
// one cycle after pop_valid.
module rpn_stack_reader
    import rpn_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int RAM_LAT = 1
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               pop_req,
    input  logic               peek_req,
    input  logic               clr_err,
    input  logic [ADDR_W-1:0]  sp,
    rpn_stack_reader_if.master ram,
    output logic [DATA_W-1:0]  pop_data,
    output logic               pop_valid,
    output logic               sp_dec,
    output logic               busy,
    output logic               underflow,
    output state_e             dbg_state_o
);

    // Latency counter only needs to hold RAM_LAT-1.
    localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              uf_q, uf_d;

    logic pop_edge;
    logic peek_edge;

    rise_detect u_pop_edge (
        .clk     (CLOCK_50),
        .rst     (reset),
        .level_i (pop_req),
        .pulse_o (pop_edge)
    );

    rise_detect u_peek_edge (
        .clk     (CLOCK_50),
        .rst     (reset),
        .level_i (peek_req),
        .pulse_o (peek_edge)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_PEEK;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            uf_q    <= uf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        uf_d    = uf_q;

        // A same-cycle underflow event below overrides this clear.
        if (clr_err) begin
            uf_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (pop_edge || peek_edge) begin
                    if (sp == '0) begin
                        uf_d = 1'b1;
                    end else begin
                        addr_d  = sp - ADDR_ONE;
                        // Pop wins when both edges arrive together.
                        op_d    = pop_edge ? OP_POP : OP_PEEK;
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (RAM_LAT == 1) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Leave once the counter would reach zero, giving RAM_LAT-1
                // wait cycles so ram_q is valid in S_DONE.
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                data_d  = ram.ram_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ram.ram_addr = addr_q;
    assign ram.ram_rden = (state_q == S_READ);
    assign pop_valid    = (state_q == S_DONE);
    assign sp_dec       = (state_q == S_DONE) && (op_q == OP_POP);
    assign busy         = (state_q != S_IDLE);
    assign underflow    = uf_q;
    assign pop_data     = data_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_rpn_stack_reader.sv
// Bench for rpn_stack_reader: two instances (RAM_LAT=1 and RAM_LAT=3) share
// the same request stimulus and RAM contents. Each has its own RAM pipeline,
// reference model (busy window + acceptance rules) and scoreboard monitor.
module tb_rpn_stack_reader;
    import rpn_pkg::*;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    logic              CLOCK_50 = 1'b0;
    logic              reset;
    logic              pop_req;
    logic              peek_req;
    logic              clr_err;
    logic [ADDR_W-1:0] sp;
    logic [DATA_W-1:0] mem [0:255];
    logic              done = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;

        rpn_stack_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ram_bus ();

        logic [DATA_W-1:0] pop_data;
        logic              pop_valid;
        logic              sp_dec;
        logic              busy;
        logic              underflow;
        state_e            dbg_state;

        rpn_stack_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAM_LAT(LAT)) dut (
            .CLOCK_50    (CLOCK_50),
            .reset       (reset),
            .pop_req     (pop_req),
            .peek_req    (peek_req),
            .clr_err     (clr_err),
            .sp          (sp),
            .ram         (ram_bus),
            .pop_data    (pop_data),
            .pop_valid   (pop_valid),
            .sp_dec      (sp_dec),
            .busy        (busy),
            .underflow   (underflow),
            .dbg_state_o (dbg_state)
        );

        // Synchronous RAM with LAT cycles of read latency.
        logic [DATA_W-1:0] pipe [LAT];
        always @(posedge CLOCK_50) begin
            for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
            pipe[0] <= ram_bus.ram_rden ? mem[ram_bus.ram_addr] : '0;
        end
        assign ram_bus.ram_q = pipe[LAT-1];

        // Reference model state and scoreboard queues.
        logic [DATA_W:0]   exp_q[$];   // {is_pop, data}
        int                t_q[$];     // cycle of pop_valid
        logic [ADDR_W-1:0] rd_q[$];    // expected read address
        int                rdt_q[$];   // cycle of ram_rden
        int                cyc  = 0;
        int                cnt  = 0;   // remaining busy cycles
        logic              prev_pop  = 1'b0;
        logic              prev_peek = 1'b0;
        logic              uf   = 1'b0;
        logic [DATA_W-1:0] last = '0;
        logic              pe, ke, uf_set;
        logic [ADDR_W-1:0] top;
        logic [DATA_W:0]   e;

        always @(posedge CLOCK_50) begin
            cyc++;
            if (!reset) begin
                pe        = pop_req && !prev_pop;
                ke        = peek_req && !prev_peek;
                prev_pop  = pop_req;
                prev_peek = peek_req;
                uf_set    = 1'b0;
                if (cnt > 0) begin
                    cnt--;
                end else if (pe || ke) begin
                    if (sp == 8'd0) begin
                        uf_set = 1'b1;
                    end else begin
                        top = sp - 8'd1;
                        exp_q.push_back({pe, mem[top]});
                        t_q.push_back(cyc + LAT);
                        rd_q.push_back(top);
                        rdt_q.push_back(cyc);
                        cnt = 1 + LAT;
                    end
                end
                if (uf_set) uf = 1'b1;
                else if (clr_err) uf = 1'b0;
            end
        end

        always @(posedge reset) begin
            exp_q.delete();
            t_q.delete();
            rd_q.delete();
            rdt_q.delete();
            cnt       = 0;
            prev_pop  = 1'b0;
            prev_peek = 1'b0;
            uf        = 1'b0;
            last      = '0;
            #1;
            check($sformatf("lat%0d_async_reset", LAT),
                  {ram_bus.ram_rden, ram_bus.ram_addr, pop_data, pop_valid, sp_dec, busy, underflow, dbg_state}, '0);
        end

        always @(negedge CLOCK_50) begin
            if (reset) begin
                check($sformatf("lat%0d_reset_outputs", LAT),
                      {ram_bus.ram_rden, ram_bus.ram_addr, pop_data, pop_valid, sp_dec, busy, underflow, dbg_state}, '0);
            end else begin
                check($sformatf("lat%0d_busy", LAT), busy, cnt > 0);
                check($sformatf("lat%0d_underflow", LAT), underflow, uf);
                check($sformatf("lat%0d_pop_data", LAT), pop_data, last);
                if (ram_bus.ram_rden) begin
                    check($sformatf("lat%0d_rden_expected", LAT), rd_q.size() != 0, 1'b1);
                    if (rd_q.size() != 0) begin
                        check($sformatf("lat%0d_ram_addr", LAT), ram_bus.ram_addr, rd_q.pop_front());
                        check($sformatf("lat%0d_rden_cycle", LAT), cyc, rdt_q.pop_front());
                    end
                end else if (rdt_q.size() != 0 && cyc > rdt_q[0]) begin
                    check($sformatf("lat%0d_rden_late_cycle", LAT), cyc, rdt_q[0]);
                    void'(rd_q.pop_front());
                    void'(rdt_q.pop_front());
                end
                if (pop_valid) begin
                    check($sformatf("lat%0d_valid_expected", LAT), exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check($sformatf("lat%0d_sp_dec", LAT), sp_dec, e[DATA_W]);
                        check($sformatf("lat%0d_valid_cycle", LAT), cyc, t_q.pop_front());
                        last = e[DATA_W-1:0];
                    end
                end else begin
                    if (sp_dec) check($sformatf("lat%0d_stray_sp_dec", LAT), sp_dec, 1'b0);
                    if (t_q.size() != 0 && cyc > t_q[0]) begin
                        check($sformatf("lat%0d_valid_late_cycle", LAT), cyc, t_q[0]);
                        void'(exp_q.pop_front());
                        void'(t_q.pop_front());
                    end
                end
            end
        end

        initial begin
            wait (done);
            check($sformatf("lat%0d_queues_drained", LAT), exp_q.size() + rd_q.size(), 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic pulse(input logic do_pop, input logic do_peek);
        pop_req  = do_pop;
        peek_req = do_peek;
        tick(1);
        pop_req  = 1'b0;
        peek_req = 1'b0;
        tick(1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0]  = 8'hC3;
        mem[1]  = 8'h96;
        mem[2]  = 8'h5A;
        mem[3]  = 8'h3C;
        mem[15] = 8'hE7;

        reset = 1'b1; pop_req = 1'b0; peek_req = 1'b0; clr_err = 1'b0; sp = '0;
        tick(3);
        #2 reset = 1'b0;
        tick(2);

        // Pop of RAM[2].
        sp = 8'd3; pulse(1'b1, 1'b0); tick(6);

        // Underflow, clear, then clear racing a new underflow.
        sp = 8'd0; pulse(1'b1, 1'b0); tick(2);
        clr_err = 1'b1; tick(1); clr_err = 1'b0; tick(1);
        pop_req = 1'b1; clr_err = 1'b1; tick(1);
        pop_req = 1'b0; clr_err = 1'b0; tick(2);
        clr_err = 1'b1; tick(1); clr_err = 1'b0; tick(1);

        // Peek of RAM[0]: no sp_dec.
        sp = 8'd1; pulse(1'b0, 1'b1); tick(6);

        // Held request gives one pop; simultaneous pop+peek gives a pop.
        sp = 8'd4; pop_req = 1'b1; tick(20); pop_req = 1'b0; tick(6);
        sp = 8'd4; pulse(1'b1, 1'b1); tick(6);

        // Top at 0x0F, second edge while busy is dropped.
        sp = 8'h10; pulse(1'b1, 1'b0); pulse(1'b1, 1'b0); tick(8);

        // Reset while the RAM_LAT=3 instance sits in S_WAIT.
        sp = 8'd5; pulse(1'b1, 1'b0); tick(1);
        #2 reset = 1'b1;
        tick(2);
        #2 reset = 1'b0;
        tick(1);
        sp = 8'd2; pulse(1'b1, 1'b0); tick(6);

        // Random traffic, including sp changes while busy.
        repeat (400) begin
            pop_req  = ($urandom_range(0, 3) == 0);
            peek_req = ($urandom_range(0, 4) == 0);
            clr_err  = ($urandom_range(0, 7) == 0);
            sp       = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            tick(1);
        end
        pop_req = 1'b0; peek_req = 1'b0; clr_err = 1'b0;
        tick(10);

        done = 1'b1;
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
